// File: rtl/fifo_bank_pkg.sv
// fifo_bank shared parameters and helpers.
// Width/depth defaults used by the bank, channels and interface.
package fifo_bank_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int WORD_SIZE = 10;
    localparam int PTR       = 3;
    localparam int NUM_CH    = 4;
    localparam int CH_W      = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
    localparam int DEPTH     = 1 << PTR;
    localparam int CNT_W     = PTR + 1;

endpackage

// File: rtl/fifo_bank_if.sv
// fifo_bank_if: channel-tagged write port, read port and status.
// master = producer/consumer side, slave = the bank.
interface fifo_bank_if;
    import fifo_bank_pkg::*;

    logic                 push;
    logic [CH_W-1:0]      push_ch;
    logic [WORD_SIZE-1:0] fifo_data_in;
    logic                 pop;
    logic [PTR-1:0]       full_threshold;
    logic [PTR-1:0]       empty_threshold;
    logic [WORD_SIZE-1:0] fifo_data_out;
    logic [CH_W-1:0]      data_out_ch;
    logic                 valid;
    logic [NUM_CH-1:0]    fifo_full;
    logic [NUM_CH-1:0]    fifo_empty;
    logic [NUM_CH-1:0]    almost_full;
    logic [NUM_CH-1:0]    almost_empty;
    logic [NUM_CH-1:0]    error;

    modport master (
        output push, push_ch, fifo_data_in, pop,
        output full_threshold, empty_threshold,
        input  fifo_data_out, data_out_ch, valid,
        input  fifo_full, fifo_empty, almost_full, almost_empty, error
    );

    modport slave (
        input  push, push_ch, fifo_data_in, pop,
        input  full_threshold, empty_threshold,
        output fifo_data_out, data_out_ch, valid,
        output fifo_full, fifo_empty, almost_full, almost_empty, error
    );

endinterface

// File: rtl/fifo_bank_ch.sv
// fifo_ch: one circular buffer with count, status flags and sticky error.
// A push into a full buffer is dropped and latches the error bit.
module fifo_ch
    import fifo_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_deq,
    input  logic [PTR-1:0]       i_full_th,
    input  logic [PTR-1:0]       i_empty_th,
    output logic [WORD_SIZE-1:0] o_head,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_afull,
    output logic                 o_aempty,
    output logic                 o_error
);

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [PTR-1:0]       r_wr;
    logic [PTR-1:0]       r_rd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic                 w_wr;
    logic                 w_rd;
    logic [CNT_W-1:0]     w_fth;
    logic [CNT_W-1:0]     w_eth;

    assign w_wr  = i_push && !o_full;
    assign w_rd  = i_deq && !o_empty;
    assign w_fth = {1'b0, i_full_th};
    assign w_eth = {1'b0, i_empty_th};

    // Storage: no reset, the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

    // Pointers, occupancy and sticky overflow error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (i_push && o_full) r_err <= 1'b1;
        end
    end

    assign o_head   = r_mem[r_rd];
    assign o_full   = (r_cnt == CNT_W'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign o_afull  = (i_full_th != '0) && (r_cnt >= w_fth) && !o_full;
    assign o_aempty = !o_empty && (r_cnt <= w_eth);
    assign o_error  = r_err;

endmodule

// File: rtl/fifo_bank.sv
// fifo_bank: NUM_CH channel FIFOs, one shared write port, one read port.
// Round-robin arbiter feeds a registered valid/pop output stage.
module fifo_bank
    import fifo_bank_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fifo_bank_if.slave  bus
);

    logic [WORD_SIZE-1:0] w_head [NUM_CH];
    logic [NUM_CH-1:0]    w_empty;
    logic [NUM_CH-1:0]    w_push;
    logic [NUM_CH-1:0]    w_deq;
    logic                 w_load;
    logic                 w_found;
    logic [CH_W-1:0]      w_gnt;
    int                   w_idx;

    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_data;
    logic [CH_W-1:0]      r_ch;
    logic [CH_W-1:0]      r_last;

    assign w_load = !r_valid || bus.pop;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_push[g] = bus.push && (bus.push_ch == CH_W'(g));
        assign w_deq[g]  = w_load && w_found && (w_gnt == CH_W'(g));

        fifo_ch u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_push     (w_push[g]),
            .i_data     (bus.fifo_data_in),
            .i_deq      (w_deq[g]),
            .i_full_th  (bus.full_threshold),
            .i_empty_th (bus.empty_threshold),
            .o_head     (w_head[g]),
            .o_full     (bus.fifo_full[g]),
            .o_empty    (w_empty[g]),
            .o_afull    (bus.almost_full[g]),
            .o_aempty   (bus.almost_empty[g]),
            .o_error    (bus.error[g])
        );
    end

    // Round-robin: first non-empty channel after the last grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_last;
        w_idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (!w_found && !w_empty[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = CH_W'(w_idx);
            end
        end
    end

    // Output register: reload when empty or consumed, data held when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_head[w_gnt];
                r_ch    <= w_gnt;
                r_last  <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_empty    = w_empty;
    assign bus.valid         = r_valid;
    assign bus.fifo_data_out = r_data;
    assign bus.data_out_ch   = r_ch;

endmodule

// File: tb/tb_fifo_bank.sv
// tb_fifo_bank: directed scenarios plus random traffic against
// a queue-based reference model of the bank.
module tb_fifo_bank;
    import fifo_bank_pkg::*;

    logic clk;
    logic reset;
    fifo_bank_if bus ();

    fifo_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WORD_SIZE-1:0] mq [NUM_CH][$];
    logic [NUM_CH-1:0]    m_err;
    logic                 m_valid;
    logic [WORD_SIZE-1:0] m_dout;
    int                   m_dch;
    int                   m_last;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_err   = '0;
        m_valid = 1'b0;
        m_dout  = '0;
        m_dch   = 0;
        m_last  = NUM_CH - 1;
    endtask

    task automatic model_edge(input logic p, input int c,
                              input logic [WORD_SIZE-1:0] d, input logic pp);
        bit acc;
        int g;
        acc = 0;
        if (p && c < NUM_CH) begin
            if (mq[c].size() == DEPTH) m_err[c] = 1'b1;
            else acc = 1;
        end
        if (!m_valid || pp) begin
            g = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                int j;
                j = (m_last + k) % NUM_CH;
                if (g < 0 && mq[j].size() > 0) g = j;
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_dout  = mq[g].pop_front();
                m_dch   = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (acc) mq[c].push_back(d);
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] ef, ee, eaf, eae;
        int n;
        int ft;
        int et;
        ft = int'(bus.full_threshold);
        et = int'(bus.empty_threshold);
        for (int c = 0; c < NUM_CH; c++) begin
            n      = mq[c].size();
            ef[c]  = (n == DEPTH);
            ee[c]  = (n == 0);
            eaf[c] = (ft != 0) && (n >= ft) && (n != DEPTH);
            eae[c] = (n != 0) && (n <= et);
        end
        check("valid", 32'(bus.valid), 32'(m_valid));
        check("data_out", 32'(bus.fifo_data_out), 32'(m_dout));
        check("data_out_ch", 32'(bus.data_out_ch), 32'(m_dch));
        check("fifo_full", 32'(bus.fifo_full), 32'(ef));
        check("fifo_empty", 32'(bus.fifo_empty), 32'(ee));
        check("almost_full", 32'(bus.almost_full), 32'(eaf));
        check("almost_empty", 32'(bus.almost_empty), 32'(eae));
        check("error", 32'(bus.error), 32'(m_err));
    endtask

    task automatic step(input logic p, input int c,
                        input logic [WORD_SIZE-1:0] d, input logic pp);
        bus.push         = p;
        bus.push_ch      = CH_W'(c);
        bus.fifo_data_in = d;
        bus.pop          = pp;
        @(posedge clk);
        model_edge(p, c, d, pp);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [WORD_SIZE-1:0] exp_seq [5];
        reset                = 1'b1;
        bus.push             = 1'b0;
        bus.push_ch          = '0;
        bus.fifo_data_in     = '0;
        bus.pop              = 1'b0;
        bus.full_threshold   = '0;
        bus.empty_threshold  = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // reset then idle
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("idle_empty", 32'(bus.fifo_empty), 32'hF);

        // fill ch2 to full, overflow, drain in order
        for (int i = 1; i <= DEPTH + 1; i++) step(1, 2, WORD_SIZE'(i), 0);
        check("ch2_full", 32'(bus.fifo_full[2]), 32'd1);
        check("ch2_err_clear", 32'(bus.error[2]), 32'd0);
        step(1, 2, 10'h00A, 0);
        check("ch2_err_set", 32'(bus.error[2]), 32'd1);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            check("ch2_order", 32'(bus.fifo_data_out), 32'(i));
            step(0, 0, 0, 1);
        end
        check("ch2_drained", 32'(bus.valid), 32'd0);
        check("err_sticky", 32'(bus.error[2]), 32'd1);

        // thresholds on ch1
        do_reset();
        bus.full_threshold  = 3'd6;
        bus.empty_threshold = 3'd2;
        for (int i = 0; i < 7; i++) step(1, 1, WORD_SIZE'(10'h100 + i), 0);
        check("ch1_afull", 32'(bus.almost_full[1]), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("ch1_aempty", 32'(bus.almost_empty[1]), 32'd1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
        check("ch1_empty", 32'(bus.fifo_empty[1]), 32'd1);
        check("ch1_aempty_off", 32'(bus.almost_empty[1]), 32'd0);

        // round-robin order
        do_reset();
        step(1, 0, 10'h0A0, 0);
        step(1, 0, 10'h0A1, 0);
        step(1, 1, 10'h0B0, 0);
        step(1, 3, 10'h0D0, 0);
        step(1, 3, 10'h0D1, 0);
        exp_seq = '{10'h0A0, 10'h0B0, 10'h0D0, 10'h0A1, 10'h0D1};
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 32'(bus.fifo_data_out), 32'(exp_seq[i]));
            step(0, 0, 0, 1);
        end
        check("rr_done", 32'(bus.valid), 32'd0);

        // streaming through ch0 at one word per cycle
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, WORD_SIZE'(10'h200 + i), 1);
        check("stream_err", 32'(bus.error), 32'd0);

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 2, WORD_SIZE'(10'h050 + i), 0);
        check("pre_rst_valid", 32'(bus.valid), 32'd1);
        do_reset();
        check("rst_empty", 32'(bus.fifo_empty), 32'hF);
        step(1, 2, 10'h3FF, 0);
        check("lat_not_yet", 32'(bus.valid), 32'd0);
        step(0, 0, 0, 0);
        check("lat_valid", 32'(bus.valid), 32'd1);
        check("lat_data", 32'(bus.fifo_data_out), 32'h3FF);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                bus.full_threshold  = PTR'($urandom_range(0, DEPTH - 1));
                bus.empty_threshold = PTR'($urandom_range(0, DEPTH - 1));
            end
            step(logic'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, NUM_CH - 1)),
                 WORD_SIZE'($urandom),
                 logic'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
